// File: rtl/fp_sched_pkg.sv
// Shared types and widths for the round-robin fp adder scheduler.
package fp_sched_pkg;

    localparam int FP_W    = 32;
    localparam int OPCNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Requester and response handshake bundle between client engines and the scheduler.
interface fp_add_scheduler_if
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [FP_W*NUM_REQ-1:0] req_a;
    logic [FP_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [FP_W-1:0]         rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        // Walk from farthest to nearest so the nearest valid slot is the last write.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[ID_W'(idx)]) begin
                gnt_idx = ID_W'(idx);
                any_req = 1'b1;
            end
        end
        if (any_req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Time-shares one external fp adder among NUM_REQ requesters with round-robin grant.
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_add_scheduler_if.slave  bus,
    output logic [FP_W-1:0]    add_a,
    output logic [FP_W-1:0]    add_b,
    input  logic [FP_W-1:0]    add_sum,
    output logic               busy,
    output logic [OPCNT_W-1:0] op_count
);

    localparam int               CNT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FP_W-1:0]    add_a_q, add_a_d;
    logic [FP_W-1:0]    add_b_q, add_b_d;
    logic [FP_W-1:0]    rsp_sum_q, rsp_sum_d;
    logic [OPCNT_W-1:0] op_count_q, op_count_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        rsp_sum_d     = rsp_sum_q;
        rsp_id_d      = rsp_id_q;
        op_count_d    = op_count_q;
        bus.req_ready = '0;
        case (state_q)
            S_IDLE: begin
                // Grant is masked during reset so no requester sees a phantom transfer.
                if (any_req && rst_n) begin
                    bus.req_ready = gnt;
                    add_a_d       = bus.req_a[int'(gnt_idx)*FP_W +: FP_W];
                    add_b_d       = bus.req_b[int'(gnt_idx)*FP_W +: FP_W];
                    id_d          = gnt_idx;
                    rr_ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d         = CNT_LOAD;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_sum_d = add_sum;
                    rsp_id_d  = id_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            rsp_sum_q  <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign busy          = (state_q != S_IDLE);
    assign op_count      = op_count_q;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomized and directed bench for fp_add_scheduler against a transaction-level reference.
module tb_fp_add_scheduler;
    import fp_sched_pkg::*;

    localparam int N    = 4;
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_add_scheduler_if #(.NUM_REQ(N), .ID_W(2)) bus1 ();
    fp_add_scheduler_if #(.NUM_REQ(N), .ID_W(2)) bus3 ();

    logic [31:0] add_a1, add_b1, add_sum1, add_a3, add_b3, add_sum3, p3_0, p3_1;
    logic        busy1, busy3;
    logic [15:0] opc1, opc3;

    fp_add_scheduler #(.NUM_REQ(N), .ADD_LAT(LAT1), .ID_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .add_a(add_a1), .add_b(add_b1),
        .add_sum(add_sum1), .busy(busy1), .op_count(opc1)
    );

    fp_add_scheduler #(.NUM_REQ(N), .ADD_LAT(LAT3), .ID_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .add_a(add_a3), .add_b(add_b3),
        .add_sum(add_sum3), .busy(busy3), .op_count(opc3)
    );

    // Integer-valued floats only, so the adder model is exact arithmetic.
    function automatic logic [31:0] i2f(input int v);
        int m;
        int e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        return {(v < 0), 8'(127 + e), 23'((m << (23 - e)) & 32'h7FFFFF)};
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0) return 0;
        m = (int'(f[22:0]) | (1 << 23)) >> (23 - e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return i2f(f2i(a) + f2i(b));
    endfunction

    assign add_sum1 = fadd(add_a1, add_b1);
    always @(posedge clk) begin
        p3_0 <= fadd(add_a3, add_b3);
        p3_1 <= p3_0;
    end
    assign add_sum3 = p3_1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    int          opa [N];
    int          opb [N];
    logic [N-1:0] vld;
    bit          granted [N];
    bit          keep_valid;
    logic        rsp_rdy;

    int          cyc, m_acc, m_ptr, m_id;
    bit          m_out;
    logic [31:0] m_sum, m_adda, m_addb, vis_sum;
    logic [1:0]  vis_id;
    logic [15:0] m_cnt;
    int          glog [$];

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive1();
        for (int i = 0; i < N; i++) begin
            bus1.req_a[32*i +: 32] = i2f(opa[i]);
            bus1.req_b[32*i +: 32] = i2f(opb[i]);
        end
        bus1.req_valid = vld;
        bus1.rsp_ready = rsp_rdy;
    endtask

    task automatic model_reset();
        m_out = 0; m_ptr = 0; m_cnt = 16'h0; m_adda = 32'h0; m_addb = 32'h0;
        vis_sum = 32'h0; vis_id = 2'd0;
    endtask

    task automatic sample1();
        logic [N-1:0] er;
        int           g;
        bit           erv;
        #1;
        g  = -1;
        er = '0;
        if (rst_n && !m_out) begin
            g = rr_pick(bus1.req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
        end
        erv = m_out && (cyc >= m_acc + LAT1 + 1);
        if (erv) begin
            vis_sum = m_sum;
            vis_id  = 2'(m_id);
        end
        check_val("req_ready", 32'(bus1.req_ready), 32'(er));
        check_val("rsp_valid", 32'(bus1.rsp_valid), 32'(erv));
        check_val("busy",      32'(busy1),          32'(m_out));
        check_val("op_count",  32'(opc1),           32'(m_cnt));
        check_val("add_a",     add_a1,              m_adda);
        check_val("add_b",     add_b1,              m_addb);
        check_val("rsp_sum",   bus1.rsp_sum,        vis_sum);
        check_val("rsp_id",    32'(bus1.rsp_id),    32'(vis_id));
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_out = 1; m_acc = cyc; m_id = g;
            m_sum = i2f(opa[g] + opb[g]);
            m_adda = i2f(opa[g]); m_addb = i2f(opb[g]);
            m_ptr = (g + 1) % N;
            glog.push_back(g);
            granted[g] = 1;
        end else if (erv && bus1.rsp_ready) begin
            m_out = 0;
            m_cnt = m_cnt + 16'd1;
        end
        cyc++;
    endtask

    task automatic step_a();
        if (!keep_valid) begin
            for (int i = 0; i < N; i++) if (granted[i]) vld[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) granted[i] = 0;
        drive1();
        sample1();
    endtask

    task automatic step();
        step_a();
        @(negedge clk);
    endtask

    task automatic gen_random();
        for (int i = 0; i < N; i++) begin
            if (granted[i] || !vld[i]) begin
                vld[i] = granted[i] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                opa[i] = int'($urandom_range(0, 2000)) - 1000;
                opb[i] = int'($urandom_range(0, 2000)) - 1000;
            end else if ($urandom_range(0, 31) == 0) begin
                vld[i] = 1'b0;
            end
            granted[i] = 0;
        end
        rsp_rdy = ($urandom_range(0, 3) != 0);
        rst_n   = ($urandom_range(0, 149) != 0);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    bit seen2;

    initial begin
        vld = '0; rsp_rdy = 1'b1; keep_valid = 0; cyc = 0; m_acc = 0; m_id = 0; m_sum = 32'h0;
        for (int i = 0; i < N; i++) begin opa[i] = 0; opb[i] = 0; granted[i] = 0; end
        model_reset();
        bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = 1'b1;
        drive1();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;

        // Single request: 1.0 + 1.0
        vld = 4'b0001; opa[0] = 1; opb[0] = 1;
        step_a(); check_val("t1_ready", 32'(bus1.req_ready), 32'h1); @(negedge clk);
        step_a(); check_val("t1_wait_rv", 32'(bus1.rsp_valid), 32'h0); @(negedge clk);
        step_a();
        check_val("t1_rv", 32'(bus1.rsp_valid), 32'h1);
        check_val("t1_sum", bus1.rsp_sum, 32'h40000000);
        check_val("t1_id", 32'(bus1.rsp_id), 32'h0);
        @(negedge clk);
        step_a(); check_val("t1_opcount", 32'(opc1), 32'h1); @(negedge clk);

        // All four continuously valid after a fresh reset
        rst_n = 1'b0; step(); rst_n = 1'b1;
        glog.delete(); keep_valid = 1; seen2 = 0;
        opa[0] = 1;  opb[0] = 1;
        opa[1] = 2;  opb[1] = 5;
        opa[2] = 3;  opb[2] = -1;
        opa[3] = -4; opb[3] = 10;
        vld = 4'b1111;
        for (int k = 0; k < 40 && glog.size() < 5; k++) begin
            step_a();
            if (bus1.rsp_valid && bus1.rsp_id == 2'd2 && !seen2) begin
                seen2 = 1;
                check_val("t2_req2_sum", bus1.rsp_sum, 32'h40000000);
            end
            @(negedge clk);
        end
        check_val("t2_req2_seen", 32'(seen2), 32'h1);
        check_val("t2_ngrants", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++) check_val("t2_order", 32'(glog[i]), 32'(exp_order[i]));
        keep_valid = 0; vld = '0;
        for (int k = 0; k < 8; k++) step();

        // Backpressure on the response port
        rsp_rdy = 1'b0; vld = 4'b0100; opa[2] = 7; opb[2] = 8;
        for (int k = 0; k < 10 && !bus1.rsp_valid; k++) step();
        check_val("t3_rv_reached", 32'(bus1.rsp_valid), 32'h1);
        vld = vld | 4'b1011;
        for (int k = 0; k < 5; k++) begin
            step_a();
            check_val("t3_hold_rv", 32'(bus1.rsp_valid), 32'h1);
            check_val("t3_hold_ready", 32'(bus1.req_ready), 32'h0);
            check_val("t3_hold_busy", 32'(busy1), 32'h1);
            check_val("t3_hold_sum", bus1.rsp_sum, i2f(15));
            check_val("t3_hold_id", 32'(bus1.rsp_id), 32'h2);
            @(negedge clk);
        end
        rsp_rdy = 1'b1;
        step();
        step_a(); check_val("t3_released", 32'(bus1.rsp_valid), 32'h0); @(negedge clk);
        vld = '0;
        for (int k = 0; k < 12; k++) step();

        // ADD_LAT=3 instance: latency and operand stability
        bus3.req_valid = 4'b0010;
        bus3.req_a[32*1 +: 32] = i2f(5);
        bus3.req_b[32*1 +: 32] = i2f(-7);
        step_a();
        check_val("t4_grant", 32'(bus3.req_ready), 32'h2);
        check_val("t4_idle_busy", 32'(busy3), 32'h0);
        @(negedge clk);
        bus3.req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            step_a();
            check_val("t4_wait_rv", 32'(bus3.rsp_valid), 32'h0);
            check_val("t4_wait_busy", 32'(busy3), 32'h1);
            check_val("t4_add_a", add_a3, i2f(5));
            check_val("t4_add_b", add_b3, i2f(-7));
            @(negedge clk);
        end
        step_a();
        check_val("t4_rv", 32'(bus3.rsp_valid), 32'h1);
        check_val("t4_sum", bus3.rsp_sum, 32'hC0000000);
        check_val("t4_id", 32'(bus3.rsp_id), 32'h1);
        @(negedge clk);
        bus3.req_valid = 4'b0011;
        step_a();
        check_val("t4_done_rv", 32'(bus3.rsp_valid), 32'h0);
        check_val("t4_opcount", 32'(opc3), 32'h1);
        check_val("t4_next_grant", 32'(bus3.req_ready), 32'h1);
        @(negedge clk);
        bus3.req_valid = '0;
        for (int k = 0; k < 8; k++) step();
        check_val("t4_add_a_held", add_a3, 32'h0);

        // Reset during WAIT aborts the operation
        vld = 4'b1000; opa[3] = 2; opb[3] = 2;
        step_a(); check_val("t5_grant", 32'(bus1.req_ready), 32'h8); @(negedge clk);
        rst_n = 1'b0;
        step_a(); check_val("t5_in_wait", 32'(busy1), 32'h1); @(negedge clk);
        rst_n = 1'b1;
        step_a();
        check_val("t5_rv", 32'(bus1.rsp_valid), 32'h0);
        check_val("t5_busy", 32'(busy1), 32'h0);
        check_val("t5_add_a", add_a1, 32'h0);
        check_val("t5_add_b", add_b1, 32'h0);
        check_val("t5_sum", bus1.rsp_sum, 32'h0);
        check_val("t5_id", 32'(bus1.rsp_id), 32'h0);
        check_val("t5_opcount", 32'(opc1), 32'h0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step_a(); check_val("t5_no_rsp", 32'(bus1.rsp_valid), 32'h0); @(negedge clk);
        end
        vld = 4'b1111;
        for (int i = 0; i < N; i++) begin opa[i] = i + 1; opb[i] = 10 * i; end
        step_a(); check_val("t5_ptr0", 32'(bus1.req_ready), 32'h1); @(negedge clk);
        vld = '0;
        for (int k = 0; k < 6; k++) step();

        // op_count wrap from 0xFFFF
        force u_dut1.op_count_q = 16'hFFFF;
        #1;
        release u_dut1.op_count_q;
        m_cnt = 16'hFFFF;
        vld = 4'b0001; opa[0] = 9; opb[0] = -9;
        for (int k = 0; k < 4; k++) step();
        check_val("t6_wrap", 32'(opc1), 32'h0);

        // Random traffic with occasional resets and backpressure
        for (int k = 0; k < 3000; k++) begin
            gen_random();
            step();
        end
        rst_n = 1'b1; rsp_rdy = 1'b1; vld = '0;
        for (int i = 0; i < N; i++) granted[i] = 0;
        for (int k = 0; k < 10; k++) step();
        check_val("end_idle", 32'(busy1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_add_scheduler.md
Name: fp_add_scheduler

Overview:
Shares one single-precision floating-point adder datapath between NUM_REQ requesters. Arbitration is round-robin. Each requester uses a valid/ready handshake. The block registers the granted operand pair, drives the shared adder, waits ADD_LAT cycles, then returns the 32-bit sum tagged with the requester index through a valid/ready response port. It sits between the client engines and the combinational or pipelined fp adder instance, which lives outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADD_LAT, 1, cycles from operands driven on add_a/add_b to add_sum being valid (>=1; 0 illegal)
ID_W, 2, width of requester index; must equal clog2(NUM_REQ)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand pair valid
req_a  in  32*NUM_REQ  operand A per requester, slice i = [32*i+31:32*i]
req_b  in  32*NUM_REQ  operand B per requester, same packing
req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
add_a  out  32  operand A to shared adder
add_b  out  32  operand B to shared adder
add_sum  in  32  result from shared adder
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of requester owning rsp_sum
rsp_sum  out  32  IEEE-754 single sum
busy  out  1  high in any state other than IDLE
op_count  out  16  completed responses, wraps 0xFFFF->0

Behaviour:
- One clock domain. Reset is synchronous and active-low: all state updates on the clk rising edge when rst_n==0.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0, op_count=0, wait counter=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - g = first index i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - If such g exists: req_ready[g]=1 (combinational, only in IDLE, at most one bit set). On the edge, latch req_a[g] and req_b[g] into add_a/add_b, latch g into id_reg, set rr_ptr=(g+1) mod NUM_REQ, load counter=ADD_LAT-1, and go to WAIT.
  - If no request is valid: req_ready=0 and the state holds.
- WAIT:
  - add_a/add_b stay stable; req_ready=0.
  - If counter!=0, decrement the counter.
  - If counter==0, capture rsp_sum=add_sum and rsp_id=id_reg, set rsp_valid=1, and go to RESP.
- RESP:
  - rsp_valid=1. rsp_sum and rsp_id stay stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid=0, op_count+=1, go to IDLE.
  - A new request is never accepted in the same cycle as the response handshake.
- Latency: accept at edge T; rsp_valid is high from cycle T+ADD_LAT+1. Peak throughput is one operation per ADD_LAT+2 cycles.
- add_a/add_b hold their last value in IDLE; they are not cleared after a completion.
- Fairness: a requester that is continuously valid waits at most NUM_REQ-1 grants for others.
- Requesters must hold req_valid and operands until granted. Dropping req_valid before grant is legal; the request is simply not served.
- Reset asserted in WAIT or RESP aborts the operation: no response is issued and the requester is not re-served.
- rr_ptr wrap: after serving NUM_REQ-1, the pointer becomes 0.

Decomposition:
- Shared package fp_sched_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2
  - FP_W=32
  - op_count width OPCNT_W=16
- One sub-module, rr_arbiter (NUM_REQ): inputs req, ptr; outputs one-hot gnt, encoded gnt_idx, any_req. Purely combinational, rotate-priority search.
- Top level holds the FSM, counter, operand/response registers and op_count.

Test Plan:
1. Single request: req_valid=4'b0001, A=0x3F800000, B=0x3F800000, ADD_LAT=1, adder model → req_ready=4'b0001 in one cycle; rsp_valid 2 cycles later with rsp_sum=0x40000000, rsp_id=0; op_count=1 after handshake.
2. All four valid continuously with distinct operands, for example req2: 0x40400000+0xBF800000 → grant order 0,1,2,3,0. Req2's response is 0x40000000 with rsp_id=2. Exactly one req_ready bit is high per grant.
3. Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid stays 1, rsp_sum/rsp_id stay stable, req_ready stays 0 and busy=1. Releasing rsp_ready completes exactly one transfer.
4. ADD_LAT=3: accept at T → rsp_valid first high at T+4; add_a/add_b stay constant during T+1..T+3.
5. Reset mid-operation: drive rst_n=0 for one cycle during WAIT → next cycle all outputs are at reset values and rr_ptr=0. No rsp_valid appears for the aborted request.
6. op_count wrap: preload by running 65536 operations, or force the counter to 0xFFFF, then complete one → op_count=0x0000.
